// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational memory
// into a one-entry valid/ready slot, with redirect, run gating and zero-word halt.
module fetch_ctrl #(
  parameter logic [7:0] RESET_PC     = 8'h00,
  parameter bit         HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [7:0]  inst_pc,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam logic [AW-1:0] ALIGN_MASK = AW'(8'hFC);
  localparam logic [AW-1:0] PC_RST     = RESET_PC & ALIGN_MASK;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [AW-1:0] pc, pc_d;
  logic [DW-1:0] inst_d;
  logic [AW-1:0] inst_pc_d;
  logic          inst_valid_d;
  logic [CW-1:0] fetch_count_d;

  logic slot_free;
  logic xfer;
  logic zero_word;

  assign imem_addr = pc;
  assign slot_free = !inst_valid || inst_ready;
  assign xfer      = inst_valid && inst_ready;
  assign zero_word = HALT_ON_ZERO && (imem_data == '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next state and next datapath values; redirect overrides everything but the handshake count
  always_comb begin
    state_d       = state;
    pc_d          = pc;
    inst_d        = inst;
    inst_pc_d     = inst_pc;
    inst_valid_d  = inst_valid;
    fetch_count_d = fetch_count;

    if (xfer) begin
      inst_valid_d  = 1'b0;
      fetch_count_d = (fetch_count == '1) ? fetch_count : fetch_count + CW'(1);
    end

    if (redirect_valid) begin
      pc_d         = redirect_pc & ALIGN_MASK;
      inst_valid_d = 1'b0;
      state_d      = run ? FETCH : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (run) state_d = FETCH;
        end
        FETCH: begin
          if (!run) begin
            state_d = IDLE;
          end else if (slot_free) begin
            if (zero_word) begin
              // PC parks on the zero word so a later redirect-free resume is impossible
              state_d = HALT;
            end else begin
              inst_d       = imem_data;
              inst_pc_d    = pc;
              inst_valid_d = 1'b1;
              pc_d         = pc + AW'(4);
            end
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= PC_RST;
      inst        <= '0;
      inst_pc     <= '0;
      inst_valid  <= 1'b0;
      fetch_count <= '0;
      halted      <= 1'b0;
    end else begin
      pc          <= pc_d;
      inst        <= inst_d;
      inst_pc     <= inst_pc_d;
      inst_valid  <= inst_valid_d;
      fetch_count <= fetch_count_d;
      halted      <= (state_d == HALT);
    end
  end

endmodule
